tcb_htif_sub: RTL and testbench

//  TCB subordinate (responder) for the HTIF host-target mailbox used by conformance and firmware runs.

---
 rtl/tcb_htif_pkg.sv | 32 +++
 rtl/tcb_htif_fifo.sv | 42 ++++
 rtl/tcb_htif_sub.sv | 139 +++++++++++++
 tb/tb_tcb_htif_sub.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tcb_htif_pkg.sv
// Shared definitions for the HTIF mailbox subordinate: register offsets,
// STATUS layout and TCB transfer-size encodings.
package tcb_htif_pkg;

  localparam logic [3:0] HTIF_TOHOST   = 4'h0;
  localparam logic [3:0] HTIF_FROMHOST = 4'h4;
  localparam logic [3:0] HTIF_STATUS   = 4'h8;
  localparam logic [3:0] HTIF_CONSOLE  = 4'hC;

  localparam int STS_HALT    = 0;
  localparam int STS_TIMEOUT = 1;
  localparam int STS_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TCB_SIZ_BYTE  = 2'd0,
    TCB_SIZ_HALF  = 2'd1,
    TCB_SIZ_WORD  = 2'd2,
    TCB_SIZ_DWORD = 2'd3
  } tcb_siz_t;

  function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                              input logic       tmo,
                                              input logic       hlt);
    logic [31:0] sts;
    sts                              = '0;
    sts[STS_CNT_LSB +: 8]            = cnt;
    sts[STS_TIMEOUT]                 = tmo;
    sts[STS_HALT]                    = hlt;
    return sts;
  endfunction

endpackage

// File: rtl/tcb_htif_fifo.sv
// Console byte FIFO: synchronous, power-of-two depth, extra pointer bit so
// count = wptr - rptr distinguishes full from empty.
module tcb_htif_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_dat,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= push_dat;
        wptr              <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  assign count = wptr - rptr;
  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = count[AW];
  assign empty = (count == '0);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/tcb_htif_sub.sv
// HTIF host-target mailbox as a TCB subordinate: TOHOST/FROMHOST/STATUS/CONSOLE.
// Optional watchdog enabled by defining TCB_HTIF_TIMEOUT_EN.
module tcb_htif_sub
  import tcb_htif_pkg::*;
#(
  parameter int ADR_W    = 32,
  parameter int FIFO_DEP = 16,
  parameter int TMO_CNT  = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tcb_vld,
  input  logic             tcb_wen,
  input  logic [ADR_W-1:0] tcb_adr,
  input  logic [1:0]       tcb_siz,
  input  logic [31:0]      tcb_wdt,
  output logic [31:0]      tcb_rdt,
  output logic             tcb_err,
  output logic             tcb_rdy,
  output logic             con_vld,
  output logic [7:0]       con_dat,
  input  logic             con_rdy,
  input  logic             hst_wen,
  input  logic [31:0]      hst_wdt,
  output logic             halt,
  output logic [30:0]      exit_code,
  output logic             timeout
);

  localparam int CW = $clog2(FIFO_DEP) + 1;

  logic [3:0]    off;
  logic          trn;
  logic [31:0]   tohost;
  logic [31:0]   fromhost;
  logic [31:0]   status;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          err_c;
  logic [31:0]   rdt_c;
  logic          we_to;
  logic          we_fh;
  logic          push_c;
  logic          unused_adr;

  // the system decoder has already selected us; upper address bits are don't-care
  assign unused_adr = ^tcb_adr[ADR_W-1:4];
  assign off        = tcb_adr[3:0];
  assign tcb_rdy    = !(tcb_wen && (off == HTIF_CONSOLE) && fifo_full);
  assign trn        = tcb_vld && tcb_rdy;
  assign status     = status_word(8'(fifo_count), timeout, halt);

  always_comb begin
    err_c  = 1'b1;
    rdt_c  = '0;
    we_to  = 1'b0;
    we_fh  = 1'b0;
    push_c = 1'b0;
    case (off)
      HTIF_TOHOST: if (tcb_siz_t'(tcb_siz) == TCB_SIZ_WORD) begin
        err_c = 1'b0;
        if (tcb_wen) we_to = 1'b1;
        else         rdt_c = tohost;
      end
      HTIF_FROMHOST: if (tcb_siz_t'(tcb_siz) == TCB_SIZ_WORD) begin
        err_c = 1'b0;
        if (tcb_wen) we_fh = 1'b1;
        else         rdt_c = fromhost;
      end
      HTIF_STATUS: if (tcb_siz_t'(tcb_siz) == TCB_SIZ_WORD && !tcb_wen) begin
        err_c = 1'b0;
        rdt_c = status;
      end
      HTIF_CONSOLE: if (tcb_wen && tcb_siz_t'(tcb_siz) != TCB_SIZ_DWORD) begin
        err_c  = 1'b0;
        push_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcb_rdt   <= '0;
      tcb_err   <= 1'b0;
      tohost    <= '0;
      fromhost  <= '0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      if (trn) begin
        tcb_rdt <= rdt_c;
        tcb_err <= err_c;
      end
      // once halted the exit code is frozen; further TOHOST writes are absorbed
      if (trn && we_to && !halt) begin
        tohost <= tcb_wdt;
        if (tcb_wdt[0]) begin
          halt      <= 1'b1;
          exit_code <= tcb_wdt[31:1];
        end
      end
      if (hst_wen)            fromhost <= hst_wdt;
      else if (trn && we_fh)  fromhost <= tcb_wdt;
    end
  end

  tcb_htif_fifo #(.DEPTH(FIFO_DEP)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (trn && push_c),
    .push_dat (tcb_wdt[7:0]),
    .pop      (con_vld && con_rdy),
    .head     (con_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign con_vld = !fifo_empty;

`ifdef TCB_HTIF_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (!halt && !timeout) begin
      if (tmo_cnt == 32'(TMO_CNT - 1)) timeout <= 1'b1;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tcb_htif_sub.sv
// Bench for tcb_htif_sub: directed scenarios plus random traffic, all checked
// against a register/queue reference model of the mailbox.
module tb_tcb_htif_sub;

  localparam int DEP = 16;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tcb_vld, tcb_wen, con_rdy, hst_wen;
  logic [31:0] tcb_adr, tcb_wdt, hst_wdt;
  logic [1:0]  tcb_siz;
  logic [31:0] tcb_rdt;
  logic        tcb_err, tcb_rdy, con_vld, halt, timeout;
  logic [7:0]  con_dat;
  logic [30:0] exit_code;

  tcb_htif_sub #(.ADR_W(32), .FIFO_DEP(DEP), .TMO_CNT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tcb_vld(tcb_vld), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr), .tcb_siz(tcb_siz),
    .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err), .tcb_rdy(tcb_rdy),
    .con_vld(con_vld), .con_dat(con_dat), .con_rdy(con_rdy),
    .hst_wen(hst_wen), .hst_wdt(hst_wdt),
    .halt(halt), .exit_code(exit_code), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [31:0] m_to, m_fh, m_rdt;
  logic        m_halt, m_err, m_tmo;
  logic [30:0] m_exit;
  logic [7:0]  m_q[$];
  int          m_act;

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(m_q.size()), 6'h0, m_tmo, m_halt};
  endfunction

  task automatic m_reset();
    m_to = 0; m_fh = 0; m_rdt = 0; m_halt = 0; m_err = 0; m_tmo = 0;
    m_exit = 0; m_q.delete(); m_act = 0;
  endtask

  task automatic reset_dut();
    tcb_vld = 0; tcb_wen = 0; tcb_adr = 0; tcb_siz = 0; tcb_wdt = 0;
    hst_wen = 0; hst_wdt = 0; con_rdy = 0;
    rst_n = 0;
    #1;
    m_reset();
    chk("rst_rdt", tcb_rdt, 0);
    chk("rst_err", tcb_err, 0);
    chk("rst_rdy", tcb_rdy, 1);
    chk("rst_con_vld", con_vld, 0);
    chk("rst_con_dat", con_dat, 0);
    chk("rst_halt", halt, 0);
    chk("rst_exit", exit_code, 0);
    chk("rst_tmo", timeout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // one clock: drive, check ready, advance model, check registered outputs
  task automatic cycle(input logic v, input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic [31:0] d,
                       input logic hw, input logic [31:0] hd, input logic cr);
    logic        rdy_e, ok, pop_e;
    logic [31:0] rd, sts;
    tcb_vld = v; tcb_wen = w; tcb_adr = a; tcb_siz = s; tcb_wdt = d;
    hst_wen = hw; hst_wdt = hd; con_rdy = cr;
    #1;
    rdy_e = !(w && a[3:0] == 4'hC && m_q.size() == DEP);
    chk("rdy", tcb_rdy, rdy_e);
    pop_e = (m_q.size() > 0) && cr;
    sts   = m_status();
    if (!m_halt && !m_tmo) m_act++;
    if (pop_e) void'(m_q.pop_front());
    if (v && rdy_e) begin
      ok = 0; rd = 0;
      case (a[3:0])
        4'h0: if (s == 2'd2) begin
          ok = 1;
          if (!w) rd = m_to;
          else if (!m_halt) begin
            m_to = d;
            if (d[0]) begin m_halt = 1; m_exit = d[31:1]; end
          end
        end
        4'h4: if (s == 2'd2) begin
          ok = 1;
          if (!w) rd = m_fh;
          else    m_fh = d;
        end
        4'h8: if (s == 2'd2 && !w) begin ok = 1; rd = sts; end
        4'hC: if (w && s != 2'd3) begin ok = 1; m_q.push_back(d[7:0]); end
        default: ;
      endcase
      m_err = !ok;
      m_rdt = ok ? rd : 32'h0;
    end
    if (hw) m_fh = hd;
`ifdef TCB_HTIF_TIMEOUT_EN
    m_tmo = (m_act >= TMO);
`endif
    @(posedge clk);
    #1;
    chk("rdt", tcb_rdt, m_rdt);
    chk("err", tcb_err, m_err);
    chk("halt", halt, m_halt);
    chk("exit_code", exit_code, m_exit);
    chk("timeout", timeout, m_tmo);
    chk("con_vld", con_vld, m_q.size() > 0);
    if (m_q.size() > 0) chk("con_dat", con_dat, m_q[0]);
  endtask

  task automatic idle(input logic cr);
    cycle(0, 0, 0, 0, 0, 0, 0, cr);
  endtask

  initial begin
    reset_dut();
    cycle(1, 0, 32'h8, 2, 0, 0, 0, 0);
    chk("sts_after_rst", tcb_rdt, 32'h0);

    cycle(1, 1, 32'h0, 2, 32'h55, 0, 0, 0);
    chk("halt_set", halt, 1);
    chk("exit_2a", exit_code, 31'h2A);
    cycle(1, 1, 32'h0, 2, 32'h3, 0, 0, 0);
    chk("exit_frozen", exit_code, 31'h2A);
    chk("post_halt_err", tcb_err, 0);

    reset_dut();
    cycle(1, 1, 32'hC, 0, 32'h48, 0, 0, 0);
    cycle(1, 1, 32'hC, 0, 32'h69, 0, 0, 0);
    cycle(1, 0, 32'h8, 2, 0, 0, 0, 0);
    chk("sts_cnt2", tcb_rdt[15:8], 2);
    chk("head_h", con_dat, 8'h48);
    idle(1);
    chk("head_i", con_dat, 8'h69);
    idle(1);
    chk("con_drained", con_vld, 0);

    for (int i = 0; i < DEP; i++) cycle(1, 1, 32'hC, 2, 32'h30 + i, 0, 0, 0);
    cycle(1, 1, 32'hC, 2, 32'hAA, 0, 0, 0);
    chk("full_stall", tcb_rdy, 0);
    cycle(1, 1, 32'hC, 2, 32'hAA, 0, 0, 1);
    cycle(1, 1, 32'hC, 2, 32'hAA, 0, 0, 0);
    cycle(1, 0, 32'h8, 2, 0, 0, 0, 0);
    chk("sts_cnt16", tcb_rdt[15:8], 16);

    reset_dut();
    cycle(1, 1, 32'h0, 2, 32'h10, 0, 0, 0);
    cycle(1, 0, 32'h0, 1, 0, 0, 0, 0);
    chk("half_rd_err", tcb_err, 1);
    cycle(1, 1, 32'h8, 2, 32'hFFFF_FFFF, 0, 0, 0);
    chk("wr_sts_err", tcb_err, 1);
    cycle(1, 0, 32'hC, 2, 0, 0, 0, 0);
    chk("rd_con_err", tcb_err, 1);
    cycle(1, 0, 32'h0, 2, 0, 0, 0, 0);
    chk("tohost_kept", tcb_rdt, 32'h10);

    cycle(1, 1, 32'h4, 2, 32'h1, 1, 32'hDEAD_BEEF, 0);
    cycle(1, 0, 32'h4, 2, 0, 1, 32'h1234_5678, 0);
    chk("fh_host_wins", tcb_rdt, 32'hDEAD_BEEF);
    cycle(1, 0, 32'h4, 2, 0, 0, 0, 0);
    chk("fh_new", tcb_rdt, 32'h1234_5678);

`ifdef TCB_HTIF_TIMEOUT_EN
    reset_dut();
    repeat (TMO - 1) idle(0);
    chk("tmo_early", timeout, 0);
    idle(0);
    chk("tmo_fire", timeout, 1);
    cycle(1, 0, 32'h8, 2, 0, 0, 0, 0);
    chk("sts_tmo", tcb_rdt[1], 1);
`endif

    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      int          r;
      a = $urandom;
      r = $urandom_range(0, 15);
      if (r < 13) a[3:0] = {r[1:0], 2'b00};
      d = $urandom;
      if ($urandom_range(0, 31) != 0) d[0] = 1'b0;
      cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1), a,
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2, d,
            ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 2) == 0));
      if (n == 1500) reset_dut();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
